// File: rtl/radar_sweep_pkg.sv
// Package: radar_sweep_pkg
// Shared definitions for the radar sweep controller: FSM state encoding,
// Avalon register word addresses, CTRL bit positions and datapath widths.
package radar_sweep_pkg;

   localparam int ANGLE_W = 10;   // commanded angle width
   localparam int TIMER_W = 24;   // dwell / timeout counter width

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DWELL = 2'd1,
      ST_MEAS  = 2'd2,
      ST_STEP  = 2'd3
   } state_t;

   // register word addresses
   localparam logic [1:0] ADDR_CTRL  = 2'd0;
   localparam logic [1:0] ADDR_LIMIT = 2'd1;
   localparam logic [1:0] ADDR_DWELL = 2'd2;
   localparam logic [1:0] ADDR_ANGLE = 2'd3;

   // CTRL bit indices
   localparam int CTRL_EN       = 0;
   localparam int CTRL_IRQ_EN   = 1;
   localparam int CTRL_BUSY     = 2;
   localparam int CTRL_DIR      = 3;
   localparam int CTRL_STEP_LSB = 4;
   localparam int CTRL_STEP_MSB = 7;
   localparam int CTRL_DONE     = 8;
   localparam int CTRL_TMO      = 9;

   // LIMIT field position of MAX (MIN sits at bit 0)
   localparam int LIMIT_MAX_LSB = 16;

endpackage

// File: rtl/radar_sweep_timer.sv
// Module: radar_sweep_timer
// Loadable down-counter with a zero flag. Load has priority over counting;
// counting saturates at zero.
// Ports:
//   clk        in   system clock
//   reset_n    in   asynchronous active-low reset
//   load       in   load count from load_value
//   load_value in   W-bit value to load
//   count_en   in   decrement by one when not already zero
//   zero       out  count is zero
module radar_sweep_timer #(
   parameter int W = radar_sweep_pkg::TIMER_W
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         load,
   input  logic [W-1:0] load_value,
   input  logic         count_en,
   output logic         zero
);

   logic [W-1:0] count_reg;

   assign zero = (count_reg == '0);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count_reg <= '0;
      end else if (load) begin
         count_reg <= load_value;
      end else if (count_en && !zero) begin
         count_reg <= count_reg - W'(1);
      end
   end

endmodule

// File: rtl/radar_sweep_ctrl.sv
// Module: radar_sweep_ctrl
// Avalon-MM slave that sweeps the servo/beam angle between MIN and MAX,
// dwelling at each position, requesting one range measurement, then
// stepping; reverses at the limits and flags DONE after MIN->MAX->MIN.
// Ports:
//   clk, reset_n           clock, asynchronous active-low reset
//   address[1:0]           register word select (CTRL, LIMIT, DWELL, ANGLE)
//   chipselect, write_n    write strobe = chipselect & ~write_n
//   writedata[31:0]        write data
//   readdata[31:0]         combinational read data (latency 0)
//   meas_ack               front-end measurement complete
//   angle[ANGLE_W-1:0]     commanded angle
//   meas_req               measurement request level (held in MEAS)
//   irq                    DONE & IRQ_EN
module radar_sweep_ctrl #(
   parameter int ANGLE_W     = radar_sweep_pkg::ANGLE_W,
   parameter int DWELL_RESET = 50000,
   parameter int TIMEOUT     = 100000,
   parameter int MIN_RESET   = 0,
   parameter int MAX_RESET   = 1023
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic [1:0]         address,
   input  logic               chipselect,
   input  logic               write_n,
   input  logic [31:0]        writedata,
   output logic [31:0]        readdata,
   input  logic               meas_ack,
   output logic [ANGLE_W-1:0] angle,
   output logic               meas_req,
   output logic               irq
);

   import radar_sweep_pkg::*;

   localparam int AW1 = ANGLE_W + 1;
   localparam logic [TIMER_W-1:0] TMO_LOAD = TIMER_W'(TIMEOUT - 1);

   state_t               state_reg, state_next;
   logic                 en_reg, irq_en_reg, dir_reg, done_reg, tmo_reg;
   logic [3:0]           step_reg;
   logic [ANGLE_W-1:0]   min_reg, max_reg, angle_reg;
   logic [TIMER_W-1:0]   dwell_reg;

   logic                 wr, wr_ctrl, wr_limit, wr_dwell, wr_angle;
   logic                 dwell_load, dwell_dec, dwell_zero;
   logic                 tmo_load, tmo_dec, tmo_zero;
   logic                 do_clamp, do_step, set_tmo;
   logic [TIMER_W-1:0]   dwell_load_value;

   logic [3:0]           step_eff;
   logic [AW1-1:0]       angle_ext, min_ext, max_ext, step_ext, sum_up, min_plus;
   logic [ANGLE_W-1:0]   angle_next, clamp_angle;
   logic                 dir_next, step_done;

   // writedata bits above the widest field are never stored
   logic                 unused_wdata;
   assign unused_wdata = ^writedata[31:26];

   assign wr       = chipselect & ~write_n;
   assign wr_ctrl  = wr && (address == ADDR_CTRL);
   assign wr_limit = wr && (address == ADDR_LIMIT);
   assign wr_dwell = wr && (address == ADDR_DWELL);
   assign wr_angle = wr && (address == ADDR_ANGLE);

   assign angle    = angle_reg;
   assign meas_req = (state_reg == ST_MEAS);
   assign irq      = done_reg & irq_en_reg;

   // A dwell of N cycles loads N-1 so the exit happens on the Nth cycle.
   assign dwell_load_value = (dwell_reg == '0) ? '0 : dwell_reg - TIMER_W'(1);

   radar_sweep_timer #(.W(TIMER_W)) u_dwell_timer (
      .clk        (clk),
      .reset_n    (reset_n),
      .load       (dwell_load),
      .load_value (dwell_load_value),
      .count_en   (dwell_dec),
      .zero       (dwell_zero)
   );

   radar_sweep_timer #(.W(TIMER_W)) u_tmo_timer (
      .clk        (clk),
      .reset_n    (reset_n),
      .load       (tmo_load),
      .load_value (TMO_LOAD),
      .count_en   (tmo_dec),
      .zero       (tmo_zero)
   );

   // ---------------- FSM ----------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_reg <= ST_IDLE;
      else          state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      dwell_load = 1'b0;
      dwell_dec  = 1'b0;
      tmo_load   = 1'b0;
      tmo_dec    = 1'b0;
      do_clamp   = 1'b0;
      do_step    = 1'b0;
      set_tmo    = 1'b0;
      // clearing EN overrides everything, including a pending ack
      if (!en_reg) begin
         state_next = ST_IDLE;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               do_clamp   = 1'b1;
               dwell_load = 1'b1;
               state_next = ST_DWELL;
            end
            ST_DWELL: begin
               if (dwell_zero) begin
                  tmo_load   = 1'b1;
                  state_next = ST_MEAS;
               end else begin
                  dwell_dec = 1'b1;
               end
            end
            ST_MEAS: begin
               // ack is checked first so it wins over a same-cycle timeout
               if (meas_ack) begin
                  state_next = ST_STEP;
               end else if (tmo_zero) begin
                  set_tmo    = 1'b1;
                  state_next = ST_STEP;
               end else begin
                  tmo_dec = 1'b1;
               end
            end
            ST_STEP: begin
               do_step    = 1'b1;
               dwell_load = 1'b1;
               state_next = ST_DWELL;
            end
            default: state_next = ST_IDLE;
         endcase
      end
   end

   // ---------------- angle datapath ----------------
   assign step_eff  = (step_reg == '0) ? 4'd1 : step_reg;
   assign step_ext  = AW1'(step_eff);
   assign angle_ext = {1'b0, angle_reg};
   assign min_ext   = {1'b0, min_reg};
   assign max_ext   = {1'b0, max_reg};
   // one extra bit so neither sum can wrap
   assign sum_up    = angle_ext + step_ext;
   assign min_plus  = min_ext + step_ext;

   always_comb begin
      clamp_angle = angle_reg;
      if (min_reg >= max_reg)      clamp_angle = min_reg;
      else if (angle_reg < min_reg) clamp_angle = min_reg;
      else if (angle_reg > max_reg) clamp_angle = max_reg;
   end

   always_comb begin
      angle_next = angle_reg;
      dir_next   = dir_reg;
      step_done  = 1'b0;
      if (min_reg >= max_reg) begin
         // degenerate window: measure in place, every step completes a sweep
         angle_next = min_reg;
         step_done  = 1'b1;
      end else if (!dir_reg) begin
         if (sum_up >= max_ext) begin
            angle_next = max_reg;
            dir_next   = 1'b1;
         end else begin
            angle_next = sum_up[ANGLE_W-1:0];
         end
      end else begin
         if (angle_ext < min_plus) begin
            angle_next = min_reg;
            dir_next   = 1'b0;
            step_done  = 1'b1;
         end else begin
            angle_next = angle_reg - ANGLE_W'(step_eff);
         end
      end
   end

   // ---------------- register file ----------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         en_reg     <= 1'b0;
         irq_en_reg <= 1'b0;
         step_reg   <= 4'd1;
         done_reg   <= 1'b0;
         tmo_reg    <= 1'b0;
         dir_reg    <= 1'b0;
         min_reg    <= ANGLE_W'(MIN_RESET);
         max_reg    <= ANGLE_W'(MAX_RESET);
         dwell_reg  <= TIMER_W'(DWELL_RESET);
         angle_reg  <= ANGLE_W'(MIN_RESET);
      end else begin
         if (wr_ctrl) begin
            en_reg     <= writedata[CTRL_EN];
            irq_en_reg <= writedata[CTRL_IRQ_EN];
            step_reg   <= writedata[CTRL_STEP_MSB:CTRL_STEP_LSB];
         end
         if (wr_limit) begin
            min_reg <= writedata[ANGLE_W-1:0];
            max_reg <= writedata[LIMIT_MAX_LSB +: ANGLE_W];
         end
         if (wr_dwell) dwell_reg <= writedata[TIMER_W-1:0];

         // clamp/step only run with EN=1, software writes only with EN=0
         if (do_clamp) begin
            angle_reg <= clamp_angle;
         end else if (do_step) begin
            angle_reg <= angle_next;
            dir_reg   <= dir_next;
         end else if (wr_angle && !en_reg) begin
            angle_reg <= writedata[ANGLE_W-1:0];
         end

         // hardware set beats a same-cycle W1C
         if (do_step && step_done)               done_reg <= 1'b1;
         else if (wr_ctrl && writedata[CTRL_DONE]) done_reg <= 1'b0;

         if (set_tmo)                             tmo_reg <= 1'b1;
         else if (wr_ctrl && writedata[CTRL_TMO]) tmo_reg <= 1'b0;
      end
   end

   always_comb begin
      readdata = '0;
      case (address)
         ADDR_CTRL: begin
            readdata[CTRL_EN]                     = en_reg;
            readdata[CTRL_IRQ_EN]                 = irq_en_reg;
            readdata[CTRL_BUSY]                   = (state_reg != ST_IDLE);
            readdata[CTRL_DIR]                    = dir_reg;
            readdata[CTRL_STEP_MSB:CTRL_STEP_LSB] = step_reg;
            readdata[CTRL_DONE]                   = done_reg;
            readdata[CTRL_TMO]                    = tmo_reg;
         end
         ADDR_LIMIT: begin
            readdata[ANGLE_W-1:0]              = min_reg;
            readdata[LIMIT_MAX_LSB +: ANGLE_W] = max_reg;
         end
         ADDR_DWELL: readdata[TIMER_W-1:0] = dwell_reg;
         ADDR_ANGLE: readdata[ANGLE_W-1:0] = angle_reg;
         default:    readdata = '0;
      endcase
   end

endmodule

// File: tb/tb_radar_sweep_ctrl.sv
// Testbench: tb_radar_sweep_ctrl
// Directed checks of the radar sweep controller with hand-computed values.
module tb_radar_sweep_ctrl;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [1:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;
   logic        meas_ack;
   logic [9:0]  angle;
   logic        meas_req;
   logic        irq;

   int tests_run    = 0;
   int tests_failed = 0;

   always #5 clk = ~clk;

   radar_sweep_ctrl #(
      .ANGLE_W     (10),
      .DWELL_RESET (50000),
      .TIMEOUT     (16),
      .MIN_RESET   (0),
      .MAX_RESET   (1023)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .address    (address),
      .chipselect (chipselect),
      .write_n    (write_n),
      .writedata  (writedata),
      .readdata   (readdata),
      .meas_ack   (meas_ack),
      .angle      (angle),
      .meas_req   (meas_req),
      .irq        (irq)
   );

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end else begin
         $display("[TB] ok   %s = 0x%0h", tag, act);
      end
   endtask

   task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
      @(negedge clk);
      address    = a;
      writedata  = d;
      chipselect = 1'b1;
      write_n    = 1'b0;
      @(negedge clk);
      chipselect = 1'b0;
      write_n    = 1'b1;
   endtask

   task automatic rd(input logic [1:0] a, output logic [31:0] d);
      address = a;
      #1;
      d = readdata;
   endtask

   task automatic wait_req(input string tag, input logic [9:0] exp_angle);
      int n = 0;
      while (!meas_req && n < 200) begin
         @(negedge clk);
         n++;
      end
      check({tag, " req"}, {31'd0, meas_req}, 32'd1);
      check({tag, " angle"}, {22'd0, angle}, {22'd0, exp_angle});
   endtask

   task automatic ack_meas(input string tag);
      repeat (2) @(negedge clk);
      meas_ack = 1'b1;
      @(negedge clk);
      meas_ack = 1'b0;
      check({tag, " req drop"}, {31'd0, meas_req}, 32'd0);
   endtask

   initial begin
      logic [31:0] d;
      int          cnt;
      logic [9:0]  sweep_exp [7];

      sweep_exp = '{10'd10, 10'd20, 10'd30, 10'd40, 10'd30, 10'd20, 10'd10};
      reset_n    = 1'b0;
      chipselect = 1'b0;
      write_n    = 1'b1;
      address    = 2'd0;
      writedata  = '0;
      meas_ack   = 1'b0;
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);

      // reset state
      rd(2'd0, d); check("rst ctrl", d, 32'h0000_0010);
      rd(2'd1, d); check("rst limit", d, 32'h03FF_0000);
      rd(2'd2, d); check("rst dwell", d, 32'd50000);
      check("rst angle", {22'd0, angle}, 32'd0);
      check("rst meas_req", {31'd0, meas_req}, 32'd0);
      check("rst irq", {31'd0, irq}, 32'd0);

      // full sweep 10..40 step 10, dwell 4
      bus_write(2'd1, (32'd40 << 16) | 32'd10);
      bus_write(2'd2, 32'd4);
      bus_write(2'd0, 32'h0000_00A1);
      cnt = 0;
      while (!meas_req && cnt < 100) begin
         @(negedge clk);
         cnt++;
      end
      check("en->req latency", cnt, 32'd5);
      for (int i = 0; i < 7; i++) begin
         wait_req($sformatf("sweep%0d", i), sweep_exp[i]);
         if (i == 4) begin
            rd(2'd0, d); check("dir down", {31'd0, d[3]}, 32'd1);
         end
         if (i == 6) begin
            rd(2'd0, d); check("done before final step", {31'd0, d[8]}, 32'd0);
         end
         ack_meas($sformatf("sweep%0d", i));
      end
      @(negedge clk);
      rd(2'd0, d);
      check("done after sweep", {31'd0, d[8]}, 32'd1);
      check("dir up after sweep", {31'd0, d[3]}, 32'd0);
      check("angle at min", {22'd0, angle}, 32'd10);
      check("irq masked", {31'd0, irq}, 32'd0);

      // interrupt enable and W1C of DONE
      bus_write(2'd0, 32'h0000_00A3);
      check("irq set", {31'd0, irq}, 32'd1);
      bus_write(2'd0, 32'h0000_01A3);
      check("irq cleared", {31'd0, irq}, 32'd0);
      rd(2'd0, d);
      check("en kept", {31'd0, d[0]}, 32'd1);
      check("done cleared", {31'd0, d[8]}, 32'd0);

      bus_write(2'd0, 32'h0000_03A0);
      @(negedge clk);
      rd(2'd0, d);
      check("busy off", {31'd0, d[2]}, 32'd0);

      // measurement timeout
      bus_write(2'd3, 32'd10);
      check("angle write", {22'd0, angle}, 32'd10);
      bus_write(2'd0, 32'h0000_00A1);
      wait_req("tmo", 10'd10);
      cnt = 0;
      while (meas_req && cnt < 100) begin
         cnt++;
         @(negedge clk);
      end
      check("tmo req cycles", cnt, 32'd16);
      rd(2'd0, d);
      check("tmo flag", {31'd0, d[9]}, 32'd1);
      wait_req("tmo next", 10'd20);

      // disable mid-measurement
      bus_write(2'd0, 32'h0000_00A0);
      @(negedge clk);
      check("dis req off", {31'd0, meas_req}, 32'd0);
      rd(2'd0, d);
      check("dis busy", {31'd0, d[2]}, 32'd0);
      check("dis angle", {22'd0, angle}, 32'd20);
      meas_ack = 1'b1;
      @(negedge clk);
      meas_ack = 1'b0;
      repeat (3) @(negedge clk);
      check("late ack req", {31'd0, meas_req}, 32'd0);
      check("late ack angle", {22'd0, angle}, 32'd20);
      bus_write(2'd3, 32'h0000_0155);
      check("angle 0x155", {22'd0, angle}, 32'h155);
      rd(2'd3, d);
      check("read angle", d, 32'h155);

      // MIN = MAX: measure in place
      bus_write(2'd1, (32'd200 << 16) | 32'd200);
      bus_write(2'd0, 32'h0000_03A1);
      bus_write(2'd3, 32'd5);
      check("angle clamp", {22'd0, angle}, 32'd200);
      wait_req("inplace0", 10'd200);
      rd(2'd0, d);
      check("inplace done before", {31'd0, d[8]}, 32'd0);
      ack_meas("inplace0");
      @(negedge clk);
      rd(2'd0, d);
      check("inplace done", {31'd0, d[8]}, 32'd1);
      cnt = 0;
      while (!meas_req && cnt < 100) begin
         @(negedge clk);
         cnt++;
      end
      check("inplace gap", cnt, 32'd4);
      check("inplace angle", {22'd0, angle}, 32'd200);
      ack_meas("inplace1");

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
